// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port unified memory between the instruction-fetch (IF)
//   and load/store (LS) units. Only one memory transaction is in flight at a
//   time. LS normally wins, but after MAX_LS_STREAK LS grants in a row while
//   IF waits, IF is forced through. A watchdog aborts a transaction whose
//   memory never answers and flags it with bus_err.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no transaction; arbitrate current requests every edge
//   XFER_IF | fetch on the bus, waiting for mem_ready or timeout
//   XFER_LS | load/store on the bus, waiting for mem_ready or timeout
//
// Ports
//   clk, reset          : system clock; synchronous active-low reset
//   if_req/if_addr      : fetch request (held until if_gnt)
//   if_gnt/if_valid     : accept pulse / completion pulse
//   if_rdata            : last fetched word
//   ls_req/we/addr/wdata: load/store request (held until ls_gnt)
//   ls_gnt/ls_valid     : accept pulse / completion pulse
//   ls_rdata            : last loaded word (stores leave it alone)
//   mem_*               : registered memory request, mem_rdata/mem_ready back
//   bus_err             : pulses with x_valid when a transaction was aborted
//   busy                : high while a transaction is outstanding
module mem_bus_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_valid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err,
  output logic          busy
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, XFER_IF, XFER_LS} state_t;

  state_t        r_state;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_tmo;
  logic          r_if_gnt, r_if_valid, r_ls_gnt, r_ls_valid, r_bus_err, r_busy;
  logic [DW-1:0] r_if_rdata, r_ls_rdata;
  logic          r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic w_streak_full, w_pick_ls, w_pick_if, w_tmo_hit;

  // IF is forced only when both request and LS has used up its streak.
  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_pick_ls     = ls_req && !(if_req && w_streak_full);
  assign w_pick_if     = if_req && !w_pick_ls;
  assign w_tmo_hit     = (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_tmo       <= '0;
      r_if_gnt    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_ls_valid  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_gnt   <= 1'b0;
      r_ls_gnt   <= 1'b0;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_ls) begin
            r_state     <= XFER_LS;
            r_busy      <= 1'b1;
            r_ls_gnt    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= ls_we;
            r_mem_addr  <= ls_addr;
            r_mem_wdata <= ls_wdata;
            // Streak only grows while IF is actually being held off.
            if (!if_req)
              r_streak <= '0;
            else if (!w_streak_full)
              r_streak <= r_streak + 1'b1;
          end else if (w_pick_if) begin
            r_state     <= XFER_IF;
            r_busy      <= 1'b1;
            r_if_gnt    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_streak    <= '0;
          end
        end
        XFER_IF, XFER_LS: begin
          // mem_ready is checked first so a late answer on the last
          // watchdog cycle still completes cleanly.
          if (mem_ready) begin
            if (r_state == XFER_IF) begin
              r_if_rdata <= mem_rdata;
              r_if_valid <= 1'b1;
            end else begin
              if (!r_mem_we)
                r_ls_rdata <= mem_rdata;
              r_ls_valid <= 1'b1;
            end
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_tmo     <= '0;
          end else if (w_tmo_hit) begin
            if (r_state == XFER_IF)
              r_if_valid <= 1'b1;
            else
              r_ls_valid <= 1'b1;
            r_bus_err <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_tmo     <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_tmo     <= '0;
        end
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign ls_gnt    = r_ls_gnt;
  assign ls_valid  = r_ls_valid;
  assign ls_rdata  = r_ls_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign bus_err   = r_bus_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_valid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_req, mem_we, mem_ready, bus_err, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_LS_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus knobs
  bit          auto_if = 0, auto_ls = 0, withdraw = 0, fixed_en = 0;
  int          if_pct = 0, ls_pct = 0, we_pct = 50, lat_max = 0, abort_pct = 0;
  int          force_lat = 0;
  logic [DW-1:0] fixed_val = '0;
  int          mem_cnt = 0, mem_lat = 0;
  string       glog = "";

  // Reference model: who owns the bus, how long it has been on it, and how
  // many LS grants in a row have been made while IF was waiting.
  int            m_owner = 0;   // 0 none, 1 IF, 2 LS
  int            m_age = 0;     // cycles mem_req has been up for this transaction
  int            m_streak = 0;
  logic          e_if_gnt, e_ls_gnt, e_if_valid, e_ls_valid, e_bus_err;
  logic          e_mem_req, e_mem_we;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_if_rdata, e_ls_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    e_if_gnt = 0; e_ls_gnt = 0; e_if_valid = 0; e_ls_valid = 0; e_bus_err = 0;
    if (!reset) begin
      m_owner = 0; m_age = 0; m_streak = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_if_rdata = '0; e_ls_rdata = '0;
    end else if (m_owner == 0) begin
      if (ls_req && !(if_req && m_streak == MAXS)) begin
        m_owner = 2; m_age = 1; e_ls_gnt = 1;
        e_mem_req = 1; e_mem_we = ls_we; e_mem_addr = ls_addr; e_mem_wdata = ls_wdata;
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (if_req) begin
        m_owner = 1; m_age = 1; e_if_gnt = 1;
        e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr;
        m_streak = 0;
      end
    end else if (mem_ready) begin
      if (m_owner == 1) begin e_if_valid = 1; e_if_rdata = mem_rdata; end
      else begin e_ls_valid = 1; if (!e_mem_we) e_ls_rdata = mem_rdata; end
      m_owner = 0; e_mem_req = 0;
    end else if (m_age == TMO) begin
      // Memory silent for the whole watchdog window.
      if (m_owner == 1) e_if_valid = 1; else e_ls_valid = 1;
      e_bus_err = 1; m_owner = 0; e_mem_req = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_all();
    chk("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
    chk("ls_gnt", 64'(ls_gnt), 64'(e_ls_gnt));
    chk("if_valid", 64'(if_valid), 64'(e_if_valid));
    chk("ls_valid", 64'(ls_valid), 64'(e_ls_valid));
    chk("bus_err", 64'(bus_err), 64'(e_bus_err));
    chk("busy", 64'(busy), 64'(m_owner != 0));
    chk("mem_req", 64'(mem_req), 64'(e_mem_req));
    chk("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
    chk("ls_rdata", 64'(ls_rdata), 64'(e_ls_rdata));
    if (e_mem_req) begin
      chk("mem_we", 64'(mem_we), 64'(e_mem_we));
      chk("mem_addr", 64'(mem_addr), 64'(e_mem_addr));
      if (e_mem_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_mem_wdata));
    end
  endtask

  // Requesters and memory responder, evaluated on the falling edge.
  task automatic drive();
    if (if_gnt) if_req = 0;
    if (ls_gnt) ls_req = 0;
    if (auto_if) begin
      if (!if_req) begin
        if (int'($urandom_range(0, 99)) < if_pct) begin if_req = 1; if_addr = AW'($urandom); end
      end else if (withdraw && $urandom_range(0, 99) < 2) if_req = 0;
    end
    if (auto_ls) begin
      if (!ls_req) begin
        if (int'($urandom_range(0, 99)) < ls_pct) begin
          ls_req = 1; ls_addr = AW'($urandom); ls_wdata = $urandom;
          ls_we = (int'($urandom_range(0, 99)) < we_pct);
        end
      end else if (withdraw && $urandom_range(0, 99) < 2) ls_req = 0;
    end
    if (mem_req) begin
      mem_ready = (mem_cnt == mem_lat);
      mem_cnt++;
    end else begin
      mem_cnt = 0;
      if (force_lat >= 0) mem_lat = force_lat;
      else if (int'($urandom_range(0, 99)) < abort_pct) mem_lat = 1000;
      else mem_lat = int'($urandom_range(0, lat_max));
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_rdata = fixed_en ? fixed_val : $urandom;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (ls_gnt) glog = {glog, "L"};
    if (if_gnt) glog = {glog, "I"};
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return if_gnt;
      1: return ls_gnt;
      2: return if_valid;
      3: return ls_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int budget, input string tag, output int n);
    n = 0;
    do begin step(); n++; end while (!sel(w) && n < budget);
    chk(tag, 64'(sel(w)), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nreq;
    logic [DW-1:0] saved;
    bit seen_ls, seen_if;

    reset = 0; if_req = 1; if_addr = 16'h0100; ls_req = 0; ls_we = 0;
    ls_addr = '0; ls_wdata = '0; mem_ready = 0; mem_rdata = '0;

    // Reset held with a pending fetch: nothing may be granted.
    fixed_en = 1; fixed_val = 32'hDEADBEEF; force_lat = 0;
    repeat (3) begin
      step();
      chk("rst_if_gnt", 64'(if_gnt), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    end
    reset = 1;
    wait_for(0, 10, "rel_if_gnt", n);
    chk("rel_gnt_latency", 64'(n), 64'd1);
    wait_for(2, 10, "rel_if_valid", n);
    chk("rel_valid_latency", 64'(n), 64'd1);
    chk("rel_if_rdata", 64'(if_rdata), 64'hDEADBEEF);
    fixed_en = 0;

    // Simultaneous IF and LS: LS first, IF one cycle after ls_valid.
    if_req = 1; if_addr = 16'h0200;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0010; ls_wdata = '0;
    wait_for(1, 10, "prio_ls_gnt", n);
    chk("prio_no_if_gnt", 64'(if_gnt), 64'd0);
    chk("prio_addr", 64'(mem_addr), 64'h0010);
    wait_for(3, 10, "prio_ls_valid", n);
    wait_for(0, 10, "prio_if_gnt", n);
    chk("prio_if_after_ls", 64'(n), 64'd1);
    wait_for(2, 10, "prio_if_valid", n);

    // Both units saturating the bus: four LS then one forced IF.
    glog = "";
    auto_if = 1; if_pct = 100; auto_ls = 1; ls_pct = 100; we_pct = 50;
    n = 0;
    while (glog.len() < 10 && n < 200) begin step(); n++; end
    checks++;
    assert (glog == "LLLLILLLLI") else begin
      errors++;
      $error("FAIL grant_order observed=%s expected=LLLLILLLLI", glog);
    end
    auto_if = 0; auto_ls = 0; if_req = 0; ls_req = 0;
    repeat (4) step();

    // Store with three wait states.
    saved = ls_rdata;
    force_lat = 3;
    ls_req = 1; ls_we = 1; ls_addr = 16'h0020; ls_wdata = 32'h12345678;
    nreq = 0; n = 0;
    do begin
      step(); n++;
      if (mem_req) begin
        nreq++;
        chk("st_we", 64'(mem_we), 64'd1);
        chk("st_addr", 64'(mem_addr), 64'h0020);
        chk("st_wdata", 64'(mem_wdata), 64'h12345678);
      end
    end while (!ls_valid && n < 20);
    chk("st_ls_valid", 64'(ls_valid), 64'd1);
    chk("st_req_cycles", 64'(nreq), 64'd4);
    chk("st_rdata_kept", 64'(ls_rdata), 64'(saved));
    ls_we = 0;

    // Silent memory: abort after TMO cycles, then normal service resumes.
    force_lat = 1000;
    saved = if_rdata;
    if_req = 1; if_addr = 16'h0300;
    nreq = 0; n = 0;
    do begin
      step(); n++;
      if (mem_req) nreq++;
    end while (!if_valid && n < 200);
    chk("tmo_if_valid", 64'(if_valid), 64'd1);
    chk("tmo_bus_err", 64'(bus_err), 64'd1);
    chk("tmo_req_cycles", 64'(nreq), 64'(TMO));
    chk("tmo_rdata_kept", 64'(if_rdata), 64'(saved));
    force_lat = 0;
    step();
    if_req = 1; if_addr = 16'h0304;
    wait_for(2, 10, "tmo_next_valid", n);
    chk("tmo_next_no_err", 64'(bus_err), 64'd0);

    // Reset in the middle of a two-wait-state load.
    force_lat = 2;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0040;
    if_req = 1; if_addr = 16'h0400;
    wait_for(1, 10, "mid_ls_gnt", n);
    reset = 0;
    step();
    chk("mid_mem_req", 64'(mem_req), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    reset = 1;
    seen_ls = 0; seen_if = 0;
    repeat (10) begin
      step();
      if (ls_valid) seen_ls = 1;
      if (if_gnt) seen_if = 1;
    end
    chk("mid_no_ls_valid", 64'(seen_ls), 64'd0);
    chk("mid_if_granted", 64'(seen_if), 64'd1);

    // Random traffic against the model.
    force_lat = -1; lat_max = 3; abort_pct = 2;
    auto_if = 1; auto_ls = 1; if_pct = 30; ls_pct = 30; we_pct = 50; withdraw = 1;
    repeat (3000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
